// File: rtl/gen_sequencer.sv
// Game-of-Life generation sequencer: issues rows 0..ROWS-1 per generation, then
// swaps the ping-pong banks on frame_end. It also arbitrates host load against calc.
module gen_sequencer #(
  parameter int ROWS        = 720,
  parameter int ROW_AW      = 10,
  parameter int GEN_W       = 32,
  parameter int ROW_TIMEOUT = 4096
) (
  input  logic              out_stream_aclk,
  input  logic              periph_reset,
  input  logic              run,
  input  logic              step,
  input  logic              load_req,
  input  logic              load_done,
  input  logic              row_done,
  input  logic              frame_end,
  input  logic              err_clr,
  output logic              row_start,
  output logic [ROW_AW-1:0] calc_row,
  output logic              bank_sel,
  output logic              load_active,
  output logic              busy,
  output logic [GEN_W-1:0]  gen_count,
  output logic              timeout_err
);

  localparam int TW = (ROW_TIMEOUT > 1) ? $clog2(ROW_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ROW, S_WAIT_FRAME
  } state_t;

  state_t            r_state;
  logic              r_row_start;
  logic [ROW_AW-1:0] r_calc_row;
  logic              r_bank_sel;
  logic              r_load_active;
  logic [GEN_W-1:0]  r_gen_count;
  logic              r_timeout_err;
  logic              r_step_pend;
  logic [TW-1:0]     r_timer;

  logic w_last_row;
  logic w_timer_max;

  assign w_last_row  = (r_calc_row == ROW_AW'(ROWS - 1));
  assign w_timer_max = (r_timer == TW'(ROW_TIMEOUT - 1));

  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      r_state       <= S_IDLE;
      r_row_start   <= 1'b0;
      r_calc_row    <= '0;
      r_bank_sel    <= 1'b0;
      r_load_active <= 1'b0;
      r_gen_count   <= '0;
      r_timeout_err <= 1'b0;
      r_step_pend   <= 1'b0;
      r_timer       <= '0;
    end else begin
      r_row_start <= 1'b0;
      if (step)    r_step_pend   <= 1'b1;
      if (err_clr) r_timeout_err <= 1'b0;
      // Later assignments below override the defaults above (clear beats set, set beats err_clr).
      case (r_state)
        S_IDLE: begin
          if (load_req) begin
            r_state       <= S_LOAD;
            r_load_active <= 1'b1;
          end else if (run || r_step_pend || step) begin
            r_state     <= S_ISSUE;
            r_row_start <= 1'b1;
            r_calc_row  <= '0;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            r_state       <= S_IDLE;
            r_gen_count   <= '0;
            r_load_active <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT_ROW;
        end
        S_WAIT_ROW: begin
          r_timer <= r_timer + 1'b1;
          if (row_done) begin
            if (w_last_row) begin
              r_state <= S_WAIT_FRAME;
            end else begin
              r_calc_row  <= r_calc_row + 1'b1;
              r_state     <= S_ISSUE;
              r_row_start <= 1'b1;
            end
          end else if (w_timer_max) begin
            r_timeout_err <= 1'b1;
            r_step_pend   <= 1'b0;
            r_calc_row    <= '0;
            r_state       <= S_IDLE;
          end
        end
        S_WAIT_FRAME: begin
          if (frame_end) begin
            r_bank_sel  <= ~r_bank_sel;
            r_gen_count <= r_gen_count + 1'b1;
            r_step_pend <= 1'b0;
            r_calc_row  <= '0;
            if (load_req) begin
              r_state       <= S_LOAD;
              r_load_active <= 1'b1;
            end else if (run) begin
              r_state     <= S_ISSUE;
              r_row_start <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign row_start   = r_row_start;
  assign calc_row    = r_calc_row;
  assign bank_sel    = r_bank_sel;
  assign load_active = r_load_active;
  assign gen_count   = r_gen_count;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state == S_ISSUE) || (r_state == S_WAIT_ROW) || (r_state == S_WAIT_FRAME);

endmodule

// File: tb/tb_gen_sequencer.sv
// Bench for gen_sequencer: acts as line buffer and video side with random row latencies,
// and tracks the expected row sequence, bank, generation count and error flag.
module tb_gen_sequencer;

  localparam int ROWS        = 720;
  localparam int ROW_AW      = 10;
  localparam int GEN_W       = 32;
  localparam int ROW_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0, step = 1'b0, load_req = 1'b0, load_done = 1'b0;
  logic              row_done = 1'b0, frame_end = 1'b0, err_clr = 1'b0;
  logic              row_start, bank_sel, load_active, busy, timeout_err;
  logic [ROW_AW-1:0] calc_row;
  logic [GEN_W-1:0]  gen_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          exp_bank = 1'b0;
  int unsigned exp_gen  = 0;

  gen_sequencer #(
    .ROWS(ROWS), .ROW_AW(ROW_AW), .GEN_W(GEN_W), .ROW_TIMEOUT(ROW_TIMEOUT)
  ) dut (
    .out_stream_aclk(clk), .periph_reset(rst), .run(run), .step(step),
    .load_req(load_req), .load_done(load_done), .row_done(row_done),
    .frame_end(frame_end), .err_clr(err_clr), .row_start(row_start),
    .calc_row(calc_row), .bank_sel(bank_sel), .load_active(load_active),
    .busy(busy), .gen_count(gen_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_row_start"}, row_start, 0);
    chk_eq({tag, "_calc_row"}, calc_row, 0);
    chk_eq({tag, "_bank_sel"}, bank_sel, 0);
    chk_eq({tag, "_load_active"}, load_active, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_gen_count"}, gen_count, 0);
    chk_eq({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Waits (bounded) for the row_start pulse and checks which row it announces.
  task automatic wait_row_start(input int exp_row);
    int i;
    i = 0;
    while (!row_start && i < 64) begin
      @(negedge clk);
      i++;
    end
    chk_eq("row_start_seen", row_start, 1);
    chk_eq("calc_row", calc_row, exp_row);
    chk_eq("busy_in_row", busy, 1);
  endtask

  // d = timer value in WAIT_ROW when row_done is sampled; spurious pulses test ignored inputs.
  task automatic serve_row(input int r, input int d, input bit stp);
    wait_row_start(r);
    if (stp) step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk_eq("row_start_width", row_start, 0);
    if (d >= 1) begin
      if ($urandom_range(0, 1) == 1) frame_end = 1'b1;
      else load_done = 1'b1;
    end
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      frame_end = 1'b0;
      load_done = 1'b0;
    end
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
  endtask

  task automatic serve_rows(input int first, input int last);
    for (int r = first; r <= last; r++) serve_row(r, $urandom_range(0, 3), 1'b0);
  endtask

  task automatic finish_gen(input bit exp_issue, input bit exp_load, input bit step_too);
    bit extra;
    extra = 1'b0;
    chk_eq("frame_hold_row", calc_row, ROWS - 1);
    for (int i = 0; i < 5; i++) begin
      if (row_start || !busy || bank_sel !== exp_bank) extra = 1'b1;
      @(negedge clk);
    end
    chk_eq("wait_frame_stable", extra, 0);
    frame_end = 1'b1;
    if (step_too) step = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    step = 1'b0;
    exp_bank = ~exp_bank;
    exp_gen++;
    chk_eq("swap_bank", bank_sel, exp_bank);
    chk_eq("swap_gen", gen_count, exp_gen);
    chk_eq("swap_row0", calc_row, 0);
    chk_eq("swap_issue", row_start, exp_issue);
    chk_eq("swap_load", load_active, exp_load);
    chk_eq("swap_busy", busy, exp_issue);
  endtask

  task automatic idle_quiet(input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (row_start || busy) seen = 1'b1;
    end
    chk_eq("idle_quiet", seen, 0);
  endtask

  // Withholds row_done for row r; optionally pulses err_clr in the timeout cycle.
  task automatic withhold(input int r, input bit clr_at_timeout);
    wait_row_start(r);
    for (int i = 1; i <= ROW_TIMEOUT; i++) begin
      @(negedge clk);
      if (i == ROW_TIMEOUT && clr_at_timeout) err_clr = 1'b1;
    end
    chk_eq("pre_timeout_err", timeout_err, 0);
    chk_eq("pre_timeout_busy", busy, 1);
    @(negedge clk);
    err_clr = 1'b0;
    chk_eq("timeout_err", timeout_err, 1);
    chk_eq("timeout_busy", busy, 0);
    chk_eq("timeout_row0", calc_row, 0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Single step from IDLE: exactly one generation.
    pulse_step();
    serve_rows(0, ROWS - 1);
    finish_gen(1'b0, 1'b0, 1'b0);
    idle_quiet(10);

    // Step during a generation and step at completion are both absorbed.
    pulse_step();
    serve_rows(0, 9);
    serve_row(10, 1, 1'b1);
    serve_rows(11, ROWS - 1);
    finish_gen(1'b0, 1'b0, 1'b1);
    idle_quiet(10);

    // Continuous run: back-to-back generations, then a deferred load request.
    run = 1'b1;
    serve_rows(0, ROWS - 1);
    finish_gen(1'b1, 1'b0, 1'b0);
    serve_rows(0, 299);
    load_req = 1'b1;
    serve_rows(300, ROWS - 1);
    finish_gen(1'b0, 1'b1, 1'b0);

    // In LOAD: step is latched, run ignored.
    pulse_step();
    run = 1'b0;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("load_active", load_active, 1);
    chk_eq("load_busy", busy, 0);
    chk_eq("load_gen_kept", gen_count, exp_gen);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    exp_gen = 0;
    chk_eq("load_done_gen", gen_count, 0);
    chk_eq("load_done_active", load_active, 0);
    chk_eq("load_done_busy", busy, 0);

    // Latched step starts a generation; row 5 times out and the pending step is dropped.
    serve_rows(0, 4);
    withhold(5, 1'b0);
    idle_quiet(20);
    chk_eq("timeout_bank", bank_sel, exp_bank);
    chk_eq("timeout_gen", gen_count, exp_gen);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_eq("err_clr", timeout_err, 0);

    // row_done in the final timer cycle wins; a later timeout beats a coincident err_clr.
    pulse_step();
    serve_rows(0, 2);
    serve_row(3, ROW_TIMEOUT - 1, 1'b0);
    chk_eq("late_done_no_err", timeout_err, 0);
    withhold(4, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_eq("err_clr2", timeout_err, 0);
    idle_quiet(5);

    // Get bank_sel=1, then reset asynchronously in the middle of row 100.
    pulse_step();
    serve_rows(0, ROWS - 1);
    finish_gen(1'b0, 1'b0, 1'b0);
    run = 1'b1;
    serve_rows(0, 99);
    wait_row_start(100);
    @(negedge clk);
    chk_eq("pre_rst_bank", bank_sel, 1);
    chk_eq("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_quiet(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
